// File: rtl/rst_sync_seq.sv
`timescale 1ns/1ps
// rst_sync_seq: reset synchronizer and downstream reset sequencer.
//  - rst_sync_n: rst_n with asynchronous assertion and deassertion
//    synchronized through a SYNC_STAGES-deep flop chain.
//  - core_rst_n: released HOLD_CYCLES clocks after the FSM first sees
//    rst_sync_n high; rst_done pulses for one cycle on every release.
//  - Optional soft reset, enabled by defining RST_SYNC_SEQ_SOFT_RST_EN:
//    adds soft_rst_req / soft_rst_ack. A request seen in RUN re-runs the
//    hold phase without touching rst_sync_n, and soft_rst_ack pulses
//    together with rst_done when the hold phase ends.
//
// state | meaning
// WAIT  | waiting for the synchronized reset to release (state_o 00)
// HOLD  | core reset held low while the hold counter runs (state_o 01)
// RUN   | core reset released, downstream logic running (state_o 10)
module rst_sync_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
    input  logic       soft_rst_req,
`endif
    output logic       rst_sync_n,
    output logic       core_rst_n,
    output logic       rst_done,
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
    output logic       soft_rst_ack,
`endif
    output logic [1:0] state_o
);

    // HOLD_CYCLES = 1 still needs a one-bit counter that only ever holds 0.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_HOLD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   core_q;
    logic                   core_d;
    logic                   done_q;
    logic                   done_d;
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
    // Remembers that the current hold phase was started by a soft request.
    logic                   soft_q;
    logic                   soft_d;
    logic                   ack_q;
    logic                   ack_d;
`endif

    // Synchronizer chain: cleared asynchronously, shifts in ones after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

    // FSM state and hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter stops at HOLD_LAST so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (rst_sync_n) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
                if (soft_rst_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
`endif
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the transition.
    always_comb begin
        core_d = (state_d == ST_RUN);
        done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
        soft_d = soft_q;
        if ((state_q == ST_RUN) && (state_d == ST_HOLD)) begin
            soft_d = 1'b1;
        end else if (done_d) begin
            soft_d = 1'b0;
        end
        ack_d = done_d && soft_q;
`endif
    end

    // Registered outputs so downstream resets are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_q <= 1'b0;
            done_q <= 1'b0;
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
            soft_q <= 1'b0;
            ack_q  <= 1'b0;
`endif
        end else begin
            core_q <= core_d;
            done_q <= done_d;
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
            soft_q <= soft_d;
            ack_q  <= ack_d;
`endif
        end
    end

    assign core_rst_n = core_q;
    assign rst_done   = done_q;
    assign state_o    = state_q;
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
    assign soft_rst_ack = ack_q;
`endif

endmodule

// File: tb/tb_rst_sync_seq.sv
`timescale 1ns/1ps
// Bench for rst_sync_seq: three parameterizations share clk/rst_n.
// Expected behaviour comes from an edge-counting reference model
// plus directed constant tables for the documented release timing.
module tb_rst_sync_seq;

    localparam int N = 3;

    int ss_v [N] = '{2, 3, 4};
    int hc_v [N] = '{4, 1, 255};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
    logic soft_rst_req = 1'b0;
`endif

    logic [N-1:0]      sync_n;
    logic [N-1:0]      core_n;
    logic [N-1:0]      done_v;
    logic [N-1:0]      ack_v;
    logic [N-1:0][1:0] st;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b1;

    // Reference model state, one entry per instance.
    int m_e    [N];
    int m_rem  [N];
    bit m_run  [N];
    bit m_soft [N];
    bit m_done [N];
    bit m_ack  [N];

    always #5 clk = ~clk;

    rst_sync_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(4)) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (ack_v[0]),
`endif
        .rst_sync_n   (sync_n[0]),
        .core_rst_n   (core_n[0]),
        .rst_done     (done_v[0]),
        .state_o      (st[0])
    );

    rst_sync_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(1)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (ack_v[1]),
`endif
        .rst_sync_n   (sync_n[1]),
        .core_rst_n   (core_n[1]),
        .rst_done     (done_v[1]),
        .state_o      (st[1])
    );

    rst_sync_seq #(.SYNC_STAGES(4), .HOLD_CYCLES(255)) u_dut_c (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (ack_v[2]),
`endif
        .rst_sync_n   (sync_n[2]),
        .core_rst_n   (core_n[2]),
        .rst_done     (done_v[2]),
        .state_o      (st[2])
    );

`ifndef RST_SYNC_SEQ_SOFT_RST_EN
    assign ack_v = '0;
`endif

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit soft_sample();
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
        return soft_rst_req;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_state(input int i);
        if (m_run[i]) return 2;
        if (m_soft[i]) return 1;
        if (m_e[i] <= ss_v[i]) return 0;
        return 1;
    endfunction

    // Model: an asynchronous reset wipes the history of every instance.
    always @(negedge rst_n) begin
        for (int i = 0; i < N; i++) begin
            m_e[i] = 0; m_rem[i] = 0; m_run[i] = 0;
            m_soft[i] = 0; m_done[i] = 0; m_ack[i] = 0;
        end
    end

    // Model: count edges since release; core releases at edge SS+HC+1,
    // a soft request in RUN costs HC further edges of reset.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_done[i] = 0;
                m_ack[i]  = 0;
                if (m_e[i] < 100000) m_e[i]++;
                if (m_run[i]) begin
                    if (soft_sample()) begin
                        m_run[i]  = 0;
                        m_soft[i] = 1;
                        m_rem[i]  = hc_v[i];
                    end
                end else if (m_soft[i]) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_run[i] = 1; m_soft[i] = 0; m_done[i] = 1; m_ack[i] = 1;
                    end
                end else if (m_e[i] == ss_v[i] + hc_v[i] + 1) begin
                    m_run[i]  = 1;
                    m_done[i] = 1;
                end
            end
        end
    end

    // Continuous comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("m_sync[%0d]", i), sync_n[i], (m_e[i] >= ss_v[i]) ? 1 : 0);
                chk($sformatf("m_core[%0d]", i), core_n[i], m_run[i]);
                chk($sformatf("m_done[%0d]", i), done_v[i], m_done[i]);
                chk($sformatf("m_state[%0d]", i), st[i], exp_state(i));
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
                chk($sformatf("m_ack[%0d]", i), ack_v[i], m_ack[i]);
`endif
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_sync[%0d]", tag, i), sync_n[i], 0);
            chk($sformatf("%s_core[%0d]", tag, i), core_n[i], 0);
            chk($sformatf("%s_done[%0d]", tag, i), done_v[i], 0);
            chk($sformatf("%s_state[%0d]", tag, i), st[i], 0);
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
            chk($sformatf("%s_ack[%0d]", tag, i), ack_v[i], 0);
`endif
        end
    endtask

    // Reset 3 cycles, release before edge 1, check edges 1..8 against tables.
    task automatic run_powerup(input string tag);
        int a_sync [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
        int a_st   [8] = '{0, 0, 1, 1, 1, 1, 2, 2};
        int a_core [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
        int a_done [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        int b_sync [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
        int b_st   [8] = '{0, 0, 0, 1, 2, 2, 2, 2};
        int b_core [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int b_done [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int c_sync [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero({tag, "_rst"});
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s_a_sync_e%0d", tag, k + 1), sync_n[0], a_sync[k]);
            chk($sformatf("%s_a_state_e%0d", tag, k + 1), st[0], a_st[k]);
            chk($sformatf("%s_a_core_e%0d", tag, k + 1), core_n[0], a_core[k]);
            chk($sformatf("%s_a_done_e%0d", tag, k + 1), done_v[0], a_done[k]);
            chk($sformatf("%s_b_sync_e%0d", tag, k + 1), sync_n[1], b_sync[k]);
            chk($sformatf("%s_b_state_e%0d", tag, k + 1), st[1], b_st[k]);
            chk($sformatf("%s_b_core_e%0d", tag, k + 1), core_n[1], b_core[k]);
            chk($sformatf("%s_b_done_e%0d", tag, k + 1), done_v[1], b_done[k]);
            chk($sformatf("%s_c_sync_e%0d", tag, k + 1), sync_n[2], c_sync[k]);
        end
    endtask

    // Continue after run_powerup until the 255-cycle instance releases (edge 260).
    task automatic long_hold_check();
        for (int e = 9; e <= 261; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 259) begin
                chk("c_core_e259", core_n[2], 0);
                chk("c_state_e259", st[2], 1);
            end
            if (e == 260) begin
                chk("c_core_e260", core_n[2], 1);
                chk("c_done_e260", done_v[2], 1);
                chk("c_state_e260", st[2], 2);
            end
            if (e == 261) chk("c_done_e261", done_v[2], 0);
        end
    endtask

`ifdef RST_SYNC_SEQ_SOFT_RST_EN
    // One-cycle soft request in RUN: 4 edges of core reset, ack with done.
    task automatic soft_pulse_test();
        @(posedge clk);
        #2 soft_rst_req = 1'b1;
        @(posedge clk);
        #2 soft_rst_req = 1'b0;
        @(negedge clk);
        chk("sp_core_k", core_n[0], 0);
        chk("sp_state_k", st[0], 1);
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("sp_core_k%0d", j), core_n[0], 0);
            chk($sformatf("sp_sync_k%0d", j), sync_n[0], 1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("sp_core_k4", core_n[0], 1);
        chk("sp_ack_k4", ack_v[0], 1);
        chk("sp_done_k4", done_v[0], 1);
        @(posedge clk);
        @(negedge clk);
        chk("sp_ack_k5", ack_v[0], 0);
        chk("sp_done_k5", done_v[0], 0);
    endtask

    // Soft request only during the power-up HOLD: ignored, single rst_done.
    task automatic soft_in_hold_test();
        int acks = 0;
        int dones = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            if (e == 4) #2 soft_rst_req = 1'b1;
            if (e == 6) #2 soft_rst_req = 1'b0;
            @(negedge clk);
            acks  += int'(ack_v[0]);
            dones += int'(done_v[0]);
        end
        chk("sh_acks", acks, 0);
        chk("sh_dones", dones, 1);
    endtask

    // Request held 20 cycles in RUN: 5-edge HOLD/RUN loops, one ack each.
    task automatic soft_held_test();
        int acks = 0;
        @(posedge clk);
        #2 soft_rst_req = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk);
            if (e == 20) #2 soft_rst_req = 1'b0;
            @(negedge clk);
            acks += int'(ack_v[0]);
        end
        chk("hold_acks", acks, 4);
        chk("hold_core_end", core_n[0], 1);
    endtask
`endif

    task automatic random_phase();
        int r;
        int n;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 chk_all_zero("glitch");
                #1 rst_n = 1'b1;
            end else if (r == 2) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 chk_all_zero("lowrst");
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2 rst_n = 1'b1;
            end else begin
                n = (r == 9) ? 280 : $urandom_range(1, 30);
                for (int c = 0; c < n; c++) begin
                    @(posedge clk);
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
                    #2 soft_rst_req = ($urandom_range(0, 3) == 0);
`endif
                end
            end
        end
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
        @(posedge clk);
        #2 soft_rst_req = 1'b0;
`endif
        repeat (3) @(posedge clk);
    endtask

    initial begin
        run_powerup("pu1");
        // Abort mid-HOLD, then the full sequence must repeat exactly.
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        run_powerup("pu2");
        long_hold_check();
`ifdef RST_SYNC_SEQ_SOFT_RST_EN
        soft_pulse_test();
        soft_in_hold_test();
        soft_held_test();
`endif
        random_phase();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
